// File: rtl/accel_sample_sequencer_if.sv
// rtl/accel_sample_sequencer_if.sv - register-read request/ack bus between the sequencer and the SPI read engine
interface accel_sample_sequencer_if;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_ack;
  logic [15:0] rd_data;

  modport master (output rd_req, output rd_addr, input rd_ack, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_data);
endinterface

// File: rtl/accel_sample_sequencer.sv
// rtl/accel_sample_sequencer.sv - ticks X/Y register reads and publishes each pair with a registered update strobe
module accel_sample_sequencer #(
  parameter int unsigned SAMPLE_DIV = 250000,
  parameter int unsigned PULSE_LEN  = 4,
  parameter int unsigned TIMEOUT    = 1023,
  parameter logic [7:0]  ADDR_X     = 8'h32,
  parameter logic [7:0]  ADDR_Y     = 8'h34
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [1:0]                      SW,
  accel_sample_sequencer_if.master        rd,
  output logic [15:0]                     data_x,
  output logic [15:0]                     data_y,
  output logic                            data_update,
  output logic                            busy,
  output logic                            timeout_err
);
  localparam int unsigned TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned PW = $clog2(PULSE_LEN + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD_X, RD_Y, SETUP, PUB_HI, PUB_LO} state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          tick_pending;
  logic [1:0]    sw_m, sw_s, sw_q;
  logic [4:0]    refill_cnt;
  logic [15:0]   cap_x;
  logic [WW-1:0] wait_cnt;
  logic [PW-1:0] pulse_cnt;
  logic          pub_done;

  function automatic logic [4:0] depth(input logic [1:0] sw);
    case (sw)
      2'b00:   depth = 5'd1;
      2'b01:   depth = 5'd2;
      2'b10:   depth = 5'd4;
      default: depth = 5'd16;
    endcase
  endfunction

  assign tick     = (tick_cnt == TW'(SAMPLE_DIV - 1));
  assign pub_done = (state == PUB_LO) && (pulse_cnt == PW'(PULSE_LEN - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // A tick landing on the same edge as the clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      tick_pending <= 1'b0;
    else if (tick)     tick_pending <= 1'b1;
    else if (pub_done) tick_pending <= 1'b0;
  end

  // refill_cnt starts at 16 so a full filter window is refilled out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_m       <= 2'b00;
      sw_s       <= 2'b00;
      sw_q       <= 2'b00;
      refill_cnt <= 5'd16;
    end else begin
      sw_m <= SW;
      sw_s <= sw_m;
      if (sw_s != sw_q) begin
        sw_q       <= sw_s;
        refill_cnt <= depth(sw_s);
      end else if (pub_done && refill_cnt != 5'd0) begin
        refill_cnt <= refill_cnt - 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rd.rd_req   <= 1'b0;
      rd.rd_addr  <= ADDR_X;
      data_x      <= 16'h0000;
      data_y      <= 16'h0000;
      data_update <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      cap_x       <= 16'h0000;
      wait_cnt    <= '0;
      pulse_cnt   <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (tick_pending || refill_cnt != 5'd0) begin
            state      <= RD_X;
            rd.rd_req  <= 1'b1;
            rd.rd_addr <= ADDR_X;
            wait_cnt   <= '0;
            busy       <= 1'b1;
          end
        end
        RD_X, RD_Y: begin
          if (rd.rd_ack) begin
            wait_cnt <= '0;
            if (state == RD_X) begin
              cap_x      <= rd.rd_data;
              rd.rd_addr <= ADDR_Y;
              state      <= RD_Y;
            end else begin
              // Both halves land together on SETUP entry, a full cycle ahead of the strobe.
              data_x    <= cap_x;
              data_y    <= rd.rd_data;
              rd.rd_req <= 1'b0;
              state     <= SETUP;
            end
          end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
            rd.rd_req   <= 1'b0;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        SETUP: begin
          data_update <= 1'b1;
          pulse_cnt   <= '0;
          state       <= PUB_HI;
        end
        PUB_HI: begin
          if (pulse_cnt == PW'(PULSE_LEN - 1)) begin
            data_update <= 1'b0;
            pulse_cnt   <= '0;
            state       <= PUB_LO;
          end else begin
            pulse_cnt <= pulse_cnt + PW'(1);
          end
        end
        PUB_LO: begin
          if (pub_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            pulse_cnt <= pulse_cnt + PW'(1);
          end
        end
        default: begin
          rd.rd_req   <= 1'b0;
          data_update <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_accel_sample_sequencer.sv
// tb/tb_accel_sample_sequencer.sv - directed self-checking bench for accel_sample_sequencer
module tb_accel_sample_sequencer;
  localparam int SDIV = 50;
  localparam int PLEN = 4;
  localparam int TMO  = 1023;
  localparam logic [7:0] AX = 8'h32;
  localparam logic [7:0] AY = 8'h34;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    int          delay;
    int          exp_nx;
    int          exp_ny;
    int          exp_rise;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  SW = 2'b00;
  logic [15:0] data_x, data_y;
  logic        data_update, busy, timeout_err;

  accel_sample_sequencer_if rd();

  accel_sample_sequencer #(
    .SAMPLE_DIV(SDIV), .PULSE_LEN(PLEN), .TIMEOUT(TMO), .ADDR_X(AX), .ADDR_Y(AY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .SW(SW), .rd(rd),
    .data_x(data_x), .data_y(data_y), .data_update(data_update),
    .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] x_val = 16'h0000, y_val = 16'h0000;
  int          ack_delay = 0;
  logic        hold_off = 1'b0;
  logic        no_ack_y = 1'b0;

  int   rise_q[$];
  int   pub_count = 0, to_count = 0, to_cyc = 0;
  int   req_rise = 0, nx = 0, ny = 0, last_nx = 0, last_ny = 0, last_req_rise = 0;
  int   hi_cnt = 0, last_hi = 0;
  logic upd_prev = 1'b0, req_prev = 1'b0;
  logic [15:0] x_prev = 16'h0000, y_prev = 16'h0000;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pub(input int n, input int budget, input string name);
    int k = 0;
    while (pub_count < n && k < budget) begin next(); k++; end
    if (pub_count < n) begin
      checks++;
      failures++;
      $display("FAIL %s timed out actual=%0d publishes required=%0d", name, pub_count, n);
    end
  endtask

  function automatic int rise_at(input int k);
    if (k < rise_q.size()) return rise_q[k];
    return -1;
  endfunction

  // SPI read engine model: acks after ack_delay waiting cycles.
  initial begin
    int rsp_wait = 0;
    rd.rd_ack = 1'b0;
    rd.rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (rd.rd_req && !hold_off && !(no_ack_y && rd.rd_addr == AY)) begin
        if (rsp_wait >= ack_delay) begin
          rd.rd_ack = 1'b1;
          rd.rd_data = (rd.rd_addr == AX) ? x_val : y_val;
          rsp_wait = 0;
        end else begin
          rd.rd_ack = 1'b0;
          rsp_wait++;
        end
      end else begin
        rd.rd_ack = 1'b0;
        rsp_wait = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      hi_cnt = 0;
    end else begin
      if (rd.rd_req && !req_prev) begin req_rise = cyc; nx = 0; ny = 0; end
      if (rd.rd_req && rd.rd_addr == AX) nx++;
      if (rd.rd_req && rd.rd_addr == AY) ny++;
      if (data_update && !upd_prev) begin
        rise_q.push_back(cyc);
        last_nx = nx;
        last_ny = ny;
        last_req_rise = req_rise;
        check("setup_x_stable", data_x, x_prev);
        check("setup_y_stable", data_y, y_prev);
        pub_count++;
      end
      if (data_update) hi_cnt++;
      else if (upd_prev) begin last_hi = hi_cnt; hi_cnt = 0; end
      if (timeout_err) begin to_count++; to_cyc = cyc; end
    end
    upd_prev = reset_n & data_update;
    req_prev = reset_n & rd.rd_req;
    x_prev = data_x;
    y_prev = data_y;
  end

  initial begin
    vec_t vecs[5];
    int c, b, n, r, q, to0, p0;

    vecs[0] = '{16'h7FFF, 16'h8000, 0, 1, 1, 3};
    vecs[1] = '{16'h0000, 16'hFFFF, 3, 4, 4, 9};
    vecs[2] = '{16'hA5A5, 16'h5A5A, 1, 2, 2, 5};
    vecs[3] = '{16'h8001, 16'h0001, 5, 6, 6, 13};
    vecs[4] = '{16'h0123, 16'hFF80, 0, 1, 1, 3};

    repeat (3) next();
    check("rst_rd_req", rd.rd_req, 0);
    check("rst_rd_addr", rd.rd_addr, AX);
    check("rst_data_x", data_x, 0);
    check("rst_data_y", data_y, 0);
    check("rst_data_update", data_update, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);

    // Reset refill: 16 back-to-back publishes, then one per tick.
    x_val = 16'h0123; y_val = 16'hFF80; ack_delay = 0;
    reset_n = 1'b1;
    c = cyc;
    wait_pub(18, 400, "refill_wait");
    check("refill_first_rise", rise_at(0) - c, 4);
    check("refill_second_rise", rise_at(1) - c, 16);
    check("refill_16th_rise", rise_at(15) - c, 184);
    check("refill_17th_tick_rise", rise_at(16) - c, 204);
    check("refill_18th_tick_rise", rise_at(17) - c, 254);
    check("refill_data_x", data_x, 16'h0123);
    check("refill_data_y", data_y, 16'hFF80);

    // Steady-state vectors: handshake lengths, strobe offset, values, pulse width.
    wait_pub(pub_count + 1, 120, "sync_table");
    for (int i = 0; i < 5; i++) begin
      x_val = vecs[i].x; y_val = vecs[i].y; ack_delay = vecs[i].delay;
      n = pub_count;
      wait_pub(n + 1, 120, "vec_wait");
      check("vec_req_x_cycles", last_nx, vecs[i].exp_nx);
      check("vec_req_y_cycles", last_ny, vecs[i].exp_ny);
      check("vec_rise_offset", rise_at(n) - last_req_rise, vecs[i].exp_rise);
      check("vec_data_x", data_x, vecs[i].x);
      check("vec_data_y", data_y, vecs[i].y);
      repeat (PLEN + 1) next();
      check("vec_hi_len", last_hi, PLEN);
    end

    // SW 00->10 in the idle gap: four back-to-back publishes.
    wait_pub(pub_count + 1, 120, "sync_sw10");
    r = cyc;
    b = pub_count;
    while (cyc < r + 8) next();
    SW = 2'b10;
    wait_pub(b + 5, 200, "sw10_wait");
    check("sw10_first_rise", rise_at(b) - r, 15);
    check("sw10_second_rise", rise_at(b + 1) - r, 27);
    check("sw10_fourth_rise", rise_at(b + 3) - r, 51);
    check("sw10_next_tick_rise", rise_at(b + 4) - r, 100);

    // SW 10->01, then 11 mid-refill: reload to 16 beats the decrement.
    r = cyc;
    b = pub_count;
    while (cyc < r + 8) next();
    SW = 2'b01;
    while (cyc < r + 20) next();
    SW = 2'b11;
    wait_pub(b + 18, 400, "sw11_wait");
    check("sw11_first_rise", rise_at(b) - r, 15);
    check("sw11_reload_first", rise_at(b + 1) - r, 27);
    check("sw11_reload_last", rise_at(b + 16) - r, 207);
    check("sw11_next_tick_rise", rise_at(b + 17) - r, 250);

    // Acks held off across several ticks: one pending publish only.
    r = cyc;
    b = pub_count;
    to0 = to_count;
    while (cyc < r + 8) next();
    hold_off = 1'b1;
    while (cyc < r + 30) next();
    check("hold_idle_busy", busy, 0);
    check("hold_idle_req", rd.rd_req, 0);
    while (cyc < r + 100) next();
    check("hold_busy", busy, 1);
    check("hold_req", rd.rd_req, 1);
    check("hold_addr", rd.rd_addr, AX);
    while (cyc < r + 170) next();
    hold_off = 1'b0;
    wait_pub(b + 2, 200, "hold_wait");
    check("hold_release_rise", rise_at(b) - r, 174);
    check("hold_next_tick_rise", rise_at(b + 1) - r, 200);
    check("hold_no_timeout", to_count - to0, 0);

    // Y read never acked: single timeout pulse, nothing published, retry.
    r = cyc;
    p0 = pub_count;
    to0 = to_count;
    x_val = 16'h1111; y_val = 16'h2222; no_ack_y = 1'b1;
    n = 0;
    while (!rd.rd_req && n < 100) begin next(); n++; end
    q = cyc;
    check("to_req_start", q - r, 47);
    n = 0;
    while (!timeout_err && n < 1100) begin next(); n++; end
    no_ack_y = 1'b0;
    check("to_pulse_cycle", cyc - q, 1024);
    check("to_pulse_count", to_count - to0, 1);
    check("to_no_publish", pub_count - p0, 0);
    check("to_data_x_kept", data_x, 16'h0123);
    check("to_data_y_kept", data_y, 16'hFF80);
    check("to_req_dropped", rd.rd_req, 0);
    next();
    check("to_pulse_width", timeout_err, 0);
    check("to_retry_req", rd.rd_req, 1);
    check("to_retry_addr", rd.rd_addr, AX);
    wait_pub(p0 + 1, 50, "to_retry_wait");
    check("to_retry_rise", rise_at(p0) - q, 1028);
    check("to_retry_data_x", data_x, 16'h1111);
    check("to_retry_data_y", data_y, 16'h2222);

    // Reset asserted during PUB_HI clears outputs at once; refill restarts.
    x_val = 16'h4321; y_val = 16'h8765;
    wait_pub(pub_count + 1, 120, "sync_reset");
    next();
    check("prereset_update_high", data_update, 1);
    reset_n = 1'b0;
    SW = 2'b00;
    #1;
    check("async_rst_update", data_update, 0);
    check("async_rst_data_x", data_x, 0);
    check("async_rst_data_y", data_y, 0);
    check("async_rst_busy", busy, 0);
    repeat (3) next();
    b = pub_count;
    reset_n = 1'b1;
    c = cyc;
    wait_pub(b + 16, 300, "rerefill_wait");
    check("rerefill_first_rise", rise_at(b) - c, 4);
    check("rerefill_16th_rise", rise_at(b + 15) - c, 184);
    check("rerefill_data_x", data_x, 16'h4321);
    check("rerefill_data_y", data_y, 16'h8765);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
